// File: rtl/datapath_sequencer.sv
// datapath_sequencer: hardwired Moore control unit for the 32-bit bus datapath.
// Sequences fetch (T0/T1/TW/T2), decode, and execute of AND/OR/NEG/NOT/HALT.
// Optional feature macro: SINGLE_STEP_EN adds a 'step' input and a PAUSE state
// entered after each instruction (and after an illegal decode).
`timescale 1ns/1ps
module datapath_sequencer #(
  parameter int MEM_WAIT = 2,   // cycles held in TW (1..15)
  parameter int CNT_W    = 16   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      ir,
  output logic [15:0]      Rin,
  output logic [15:0]      Rout,
  output logic             PCin,
  output logic             PCout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IncPC,
  output logic             Zlowout,
  output logic             Read,
  output logic             AND,
  output logic             OR,
  output logic             NEG,
  output logic             NOT,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_TW, S_T2, S_DEC,
    S_E3, S_E4, S_E5, S_U3, S_U4, S_HALT, S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       opcode;
  logic             unused_ir;

  assign opcode      = ir[31:27];
  assign unused_ir   = ^ir[14:0];
  assign instr_count = cnt_q;

  // after an instruction retires (or is rejected) the sequencer refetches,
  // or waits for a step pulse when single-stepping is built in
`ifdef SINGLE_STEP_EN
  localparam state_t S_AFTER = S_PAUSE;
`else
  localparam state_t S_AFTER = S_T0;
`endif

  // state, wait counter, latched register fields and retire counter
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and next register values
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    begin state_d = S_TW; wcnt_d = WAIT_LD; end
      S_TW:    if (wcnt_q == 4'd0) state_d = S_T2;
               else wcnt_d = wcnt_q - 4'd1;
      S_T2:    state_d = S_DEC;
      S_DEC: begin
        // ir is stable here; capture fields so later ir changes are harmless
        ra_d = ir[26:23];
        rb_d = ir[22:19];
        rc_d = ir[18:15];
        op_d = opcode;
        case (opcode)
          OP_AND, OP_OR:   state_d = S_E3;
          OP_NEG, OP_NOT:  state_d = S_U3;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_AFTER;
        endcase
      end
      S_E3:    state_d = S_E4;
      S_E4:    state_d = S_E5;
      S_E5:    begin state_d = S_AFTER; cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}; end
      S_U3:    state_d = S_U4;
      S_U4:    begin state_d = S_AFTER; cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}; end
      S_HALT:  state_d = S_HALT;
`ifdef SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_T0;
`else
      S_PAUSE: state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Moore control decode; only 'illegal' also looks at the live opcode in DECODE
  always_comb begin
    Rin = '0; Rout = '0;
    PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IncPC = 1'b0;
    Zlowout = 1'b0; Read = 1'b0;
    AND = 1'b0; OR = 1'b0; NEG = 1'b0; NOT = 1'b0;
    busy = 1'b1; halted = 1'b0; illegal = 1'b0;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_T0:    begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1:    begin Zlowout = 1'b1; PCin = 1'b1; end
      S_TW:    begin Read = 1'b1; MDRin = 1'b1; end
      S_T2:    begin MDRout = 1'b1; IRin = 1'b1; end
      S_DEC:   illegal = !(opcode inside {OP_AND, OP_OR, OP_NEG, OP_NOT, OP_HALT});
      S_E3:    begin Rout = 16'd1 << rb_q; Yin = 1'b1; end
      S_E4: begin
        Rout = 16'd1 << rc_q;
        AND  = (op_q == OP_AND);
        OR   = (op_q == OP_OR);
        Zin  = 1'b1;
      end
      S_E5, S_U4: begin Zlowout = 1'b1; Rin = 16'd1 << ra_q; end
      S_U3: begin
        Rout = 16'd1 << rb_q;
        NEG  = (op_q == OP_NEG);
        NOT  = (op_q == OP_NOT);
        Zin  = 1'b1;
      end
      S_HALT:  begin busy = 1'b0; halted = 1'b1; end
      S_PAUSE: ;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer (default build, MEM_WAIT=2, CNT_W=16).
`timescale 1ns/1ps
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, IncPC, Zlowout, Read;
  logic AND, OR, NEG, NOT, busy, halted, illegal;
  logic [15:0] instr_count;
`ifdef SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IncPC(IncPC),
    .Zlowout(Zlowout), .Read(Read),
    .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  // packed view of the single-bit outputs
  logic [17:0] ctl;
  assign ctl = {PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, IncPC,
                Zlowout, Read, AND, OR, NEG, NOT, busy, halted, illegal};

  localparam logic [17:0] B_PCIN = 18'd1 << 17, B_PCOUT = 18'd1 << 16,
    B_IRIN = 18'd1 << 15, B_YIN = 18'd1 << 14, B_ZIN = 18'd1 << 13,
    B_MARIN = 18'd1 << 12, B_MDRIN = 18'd1 << 11, B_MDROUT = 18'd1 << 10,
    B_INCPC = 18'd1 << 9, B_ZLOW = 18'd1 << 8, B_READ = 18'd1 << 7,
    B_AND = 18'd1 << 6, B_OR = 18'd1 << 5, B_NEG = 18'd1 << 4, B_NOT = 18'd1 << 3,
    B_BUSY = 18'd1 << 2, B_HALT = 18'd1 << 1, B_ILL = 18'd1;

  localparam logic [17:0] C_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_BUSY;
  localparam logic [17:0] C_T1  = B_ZLOW | B_PCIN | B_BUSY;
  localparam logic [17:0] C_TW  = B_READ | B_MDRIN | B_BUSY;
  localparam logic [17:0] C_T2  = B_MDROUT | B_IRIN | B_BUSY;
  localparam logic [17:0] C_DEC = B_BUSY;
  localparam logic [17:0] C_WB  = B_ZLOW | B_BUSY;

  // AND R1,R2,R3 ; NEG R5,R7 ; opcode 00111 ; HALT
  localparam logic [31:0] IR_AND  = 32'h5091_8000;
  localparam logic [31:0] IR_NEG  = 32'h82B8_0000;
  localparam logic [31:0] IR_ILL  = 32'h3800_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one cycle, then check every control output plus bus exclusivity
  task automatic cyc(input string tag, input logic [17:0] e_ctl,
                     input logic [15:0] e_rin, input logic [15:0] e_rout);
    @(posedge clk); #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(e_ctl));
    chk({tag, ".Rin"}, 32'(Rin), 32'(e_rin));
    chk({tag, ".Rout"}, 32'(Rout), 32'(e_rout));
    chk({tag, ".bus1"}, 32'($countones({Rout, PCout, MDRout, Zlowout}) <= 1), 32'd1);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T1"}, C_T1, 16'h0, 16'h0);
    cyc({tag, ".TW1"}, C_TW, 16'h0, 16'h0);
    cyc({tag, ".TW2"}, C_TW, 16'h0, 16'h0);
    cyc({tag, ".T2"}, C_T2, 16'h0, 16'h0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; ir = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctl", 32'(ctl), 32'h0);
    chk("rst.cnt", 32'(instr_count), 32'h0);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc("idle", 18'h0, 16'h0, 16'h0);
      chk("idle.cnt", 32'(instr_count), 32'h0);
    end

    // AND R1,R2,R3 with ir swapped mid-execute: latched fields must hold
    ir = IR_AND; start = 1'b1;
    cyc("and.T0", C_T0, 16'h0, 16'h0);
    start = 1'b0;
    fetch("and");
    cyc("and.DEC", C_DEC, 16'h0, 16'h0);
    cyc("and.E3", B_YIN | B_BUSY, 16'h0, 16'h0004);
    ir = IR_NEG;
    cyc("and.E4", B_AND | B_ZIN | B_BUSY, 16'h0, 16'h0008);
    cyc("and.E5", C_WB, 16'h0002, 16'h0);
    chk("and.cnt0", 32'(instr_count), 32'h0);
    cyc("and.nextT0", C_T0, 16'h0, 16'h0);
    chk("and.cnt1", 32'(instr_count), 32'h1);

    // NEG R5,R7: T0 above through next T0 is 8 cycles
    fetch("neg");
    cyc("neg.DEC", C_DEC, 16'h0, 16'h0);
    cyc("neg.U3", B_NEG | B_ZIN | B_BUSY, 16'h0, 16'h0080);
    ir = IR_ILL;
    cyc("neg.U4", C_WB, 16'h0020, 16'h0);
    cyc("neg.nextT0", C_T0, 16'h0, 16'h0);
    chk("neg.cnt2", 32'(instr_count), 32'h2);

    // illegal opcode: one-cycle pulse, no retire, refetch
    fetch("ill");
    cyc("ill.DEC", C_DEC | B_ILL, 16'h0, 16'h0);
    cyc("ill.T0", C_T0, 16'h0, 16'h0);
    chk("ill.cnt", 32'(instr_count), 32'h2);
    ir = IR_HALT;

    // HALT: sticky, start ignored
    fetch("halt");
    cyc("halt.DEC", C_DEC, 16'h0, 16'h0);
    start = 1'b1;
    for (int i = 0; i < 20; i++) cyc("halt.hold", B_HALT, 16'h0, 16'h0);
    chk("halt.cnt", 32'(instr_count), 32'h2);

    // clr out of HALT, then clr during the second TW cycle
    start = 1'b0; clr = 1'b1;
    cyc("clr.halt", 18'h0, 16'h0, 16'h0);
    clr = 1'b0; ir = IR_AND; start = 1'b1;
    cyc("mw.T0", C_T0, 16'h0, 16'h0);
    start = 1'b0;
    cyc("mw.T1", C_T1, 16'h0, 16'h0);
    cyc("mw.TW1", C_TW, 16'h0, 16'h0);
    cyc("mw.TW2", C_TW, 16'h0, 16'h0);
    clr = 1'b1;
    cyc("mw.idle", 18'h0, 16'h0, 16'h0);
    chk("mw.cnt", 32'(instr_count), 32'h0);
    clr = 1'b0; start = 1'b1;
    cyc("re.T0", C_T0, 16'h0, 16'h0);
    start = 1'b0;
    fetch("re");
    cyc("re.DEC", C_DEC, 16'h0, 16'h0);
    cyc("re.E3", B_YIN | B_BUSY, 16'h0, 16'h0004);
    cyc("re.E4", B_AND | B_ZIN | B_BUSY, 16'h0, 16'h0008);
    cyc("re.E5", C_WB, 16'h0002, 16'h0);
    cyc("re.T0b", C_T0, 16'h0, 16'h0);
    chk("re.cnt", 32'(instr_count), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
